// File: rtl/linkspeed_pkg.sv
// Shared message/exit codes, FSM state type and verdict helpers for the LINKSPEED sequencer.
package linkspeed_pkg;

    localparam logic [3:0] MSG_START_REQ    = 4'd1;
    localparam logic [3:0] MSG_START_RESP   = 4'd2;
    localparam logic [3:0] MSG_DONE_REQ     = 4'd3;
    localparam logic [3:0] MSG_DONE_RESP    = 4'd4;
    localparam logic [3:0] MSG_REPAIR_REQ   = 4'd5;
    localparam logic [3:0] MSG_REPAIR_RESP  = 4'd6;
    localparam logic [3:0] MSG_DEGRADE_REQ  = 4'd7;
    localparam logic [3:0] MSG_DEGRADE_RESP = 4'd8;
    localparam logic [3:0] MSG_RETRAIN_REQ  = 4'd9;
    localparam logic [3:0] MSG_RETRAIN_RESP = 4'd10;

    localparam logic [2:0] EXIT_NONE    = 3'd0;
    localparam logic [2:0] EXIT_DONE    = 3'd1;
    localparam logic [2:0] EXIT_REPAIR  = 3'd2;
    localparam logic [2:0] EXIT_DEGRADE = 3'd3;
    localparam logic [2:0] EXIT_RETRAIN = 3'd4;
    localparam logic [2:0] EXIT_TIMEOUT = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_TEST,
        ST_EVAL,
        ST_RESULT,
        ST_WAIT,
        ST_EXIT
    } state_t;

    function automatic logic [2:0] severity(input logic [2:0] ex);
        case (ex)
            EXIT_DONE:    return 3'd1;
            EXIT_REPAIR:  return 3'd2;
            EXIT_DEGRADE: return 3'd3;
            EXIT_RETRAIN: return 3'd4;
            default:      return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] worst_exit(input logic [2:0] a, input logic [2:0] b);
        return (severity(a) >= severity(b)) ? a : b;
    endfunction

    function automatic logic [3:0] verdict_req(input logic [2:0] ex);
        case (ex)
            EXIT_DONE:    return MSG_DONE_REQ;
            EXIT_REPAIR:  return MSG_REPAIR_REQ;
            EXIT_DEGRADE: return MSG_DEGRADE_REQ;
            EXIT_RETRAIN: return MSG_RETRAIN_REQ;
            default:      return 4'd0;
        endcase
    endfunction

    function automatic logic [2:0] req_verdict(input logic [3:0] msg);
        case (msg)
            MSG_DONE_REQ:    return EXIT_DONE;
            MSG_REPAIR_REQ:  return EXIT_REPAIR;
            MSG_DEGRADE_REQ: return EXIT_DEGRADE;
            MSG_RETRAIN_REQ: return EXIT_RETRAIN;
            default:         return EXIT_NONE;
        endcase
    endfunction

    function automatic logic is_req(input logic [3:0] msg);
        case (msg)
            MSG_START_REQ, MSG_DONE_REQ, MSG_REPAIR_REQ,
            MSG_DEGRADE_REQ, MSG_RETRAIN_REQ: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/linkspeed_resp_arb.sv
// One-deep pending-response register plus the sideband send arbiter.
// Responses win over local requests; a send needs TX idle and a gap cycle after the previous send.
module linkspeed_resp_arb
    import linkspeed_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       rx_req_valid,
    input  logic [3:0] rx_resp_code,
    input  logic       fsm_req_valid,
    input  logic [3:0] fsm_req_code,
    input  logic       busy,
    output logic       fsm_req_taken,
    output logic       o_valid,
    output logic [3:0] o_msg
);

    logic       pend_valid;
    logic [3:0] pend_code;
    logic       can_send;
    logic       send_resp;

    always_comb begin
        can_send      = !clr && !busy && !o_valid;
        send_resp     = can_send && pend_valid;
        fsm_req_taken = can_send && !pend_valid && fsm_req_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid    <= 1'b0;
            o_msg      <= '0;
            pend_valid <= 1'b0;
            pend_code  <= '0;
        end else if (clr) begin
            o_valid    <= 1'b0;
            o_msg      <= '0;
            pend_valid <= 1'b0;
            pend_code  <= '0;
        end else begin
            o_valid <= send_resp || fsm_req_taken;
            if (send_resp) begin
                o_msg <= pend_code;
            end else if (fsm_req_taken) begin
                o_msg <= fsm_req_code;
            end
            // A request arriving while the pending one is being sent replaces it.
            if (rx_req_valid) begin
                pend_valid <= 1'b1;
                pend_code  <= rx_resp_code;
            end else if (send_resp) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/linkspeed_seq.sv
// LINKSPEED sequencer for MBTRAIN: local start/point-test/result exchange plus partner responder.
// Final exit is the most severe of local and remote verdicts, or timeout.
module linkspeed_seq
    import linkspeed_pkg::*;
#(
    parameter int unsigned NUM_LANES      = 16,
    parameter int unsigned NUM_GROUPS     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 800000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic [3:0]            i_sideband_message,
    input  logic                  i_sideband_valid,
    input  logic                  i_busy,
    input  logic                  i_point_test_ack,
    input  logic [NUM_LANES-1:0]  i_lanes_result,
    input  logic                  i_valid_framing_error,
    input  logic                  i_comming_from_repair,
    output logic                  o_valid,
    output logic [3:0]            o_sideband_message,
    output logic                  o_point_test_en,
    output logic [NUM_GROUPS-1:0] o_group_functional,
    output logic [2:0]            o_exit,
    output logic                  o_ack
);

    localparam int unsigned LANES_PER_GROUP = NUM_LANES / NUM_GROUPS;
    localparam int unsigned TMR_W           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t state, next_state;
    logic [TMR_W-1:0] timer;
    logic             timer_expired;

    logic [2:0] next_exit, exit_code, local_verdict, remote_verdict, eval_verdict, rx_verdict;
    logic       start_req_sent, start_resp_rcvd, start_answered;
    logic       own_resp_rcvd, remote_known, lanes_all_pass;
    logic       rx_active, rx_req_valid, fsm_req_valid, fsm_req_taken, arb_clr;
    logic [3:0] fsm_req_code, own_resp_code, rx_resp_code;
    logic [NUM_GROUPS-1:0] group_pass;

    genvar g;
    generate
        for (g = 0; g < NUM_GROUPS; g++) begin : g_group
            assign group_pass[g] = &i_lanes_result[g*LANES_PER_GROUP +: LANES_PER_GROUP];
        end
    endgenerate

    always_comb begin
        rx_active     = i_sideband_valid && i_en && (state != ST_IDLE);
        rx_req_valid  = rx_active && is_req(i_sideband_message);
        rx_resp_code  = i_sideband_message + 4'd1;
        rx_verdict    = req_verdict(i_sideband_message);
        own_resp_code = verdict_req(local_verdict) + 4'd1;
        arb_clr       = !i_en;
        timer_expired = (timer == TMR_LAST);
    end

    always_comb begin
        if (i_valid_framing_error) begin
            eval_verdict = EXIT_RETRAIN;
        end else if (lanes_all_pass) begin
            eval_verdict = EXIT_DONE;
        end else if ((|o_group_functional) && (NUM_GROUPS > 1) && !i_comming_from_repair) begin
            eval_verdict = EXIT_REPAIR;
        end else begin
            eval_verdict = EXIT_DEGRADE;
        end
    end

    linkspeed_resp_arb u_resp_arb (
        .clk           (clk),
        .rst           (rst),
        .clr           (arb_clr),
        .rx_req_valid  (rx_req_valid),
        .rx_resp_code  (rx_resp_code),
        .fsm_req_valid (fsm_req_valid),
        .fsm_req_code  (fsm_req_code),
        .busy          (i_busy),
        .fsm_req_taken (fsm_req_taken),
        .o_valid       (o_valid),
        .o_msg         (o_sideband_message)
    );

    // Timer restarts on every state change and saturates, so timer==0 in EXIT marks the entry cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            timer <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                timer <= '0;
            end else if (timer != TMR_LAST) begin
                timer <= timer + TMR_W'(1);
            end
        end
    end

    always_comb begin
        next_state = state;
        next_exit  = worst_exit(local_verdict, remote_verdict);
        if (!i_en) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   next_state = ST_START;
                ST_START: begin
                    if (start_req_sent && start_resp_rcvd && start_answered) begin
                        next_state = ST_TEST;
                    end else if (timer_expired) begin
                        next_state = ST_EXIT;
                        next_exit  = EXIT_TIMEOUT;
                    end
                end
                ST_TEST: begin
                    if (i_point_test_ack) begin
                        next_state = ST_EVAL;
                    end else if (timer_expired) begin
                        next_state = ST_EXIT;
                        next_exit  = EXIT_TIMEOUT;
                    end
                end
                ST_EVAL:   next_state = ST_RESULT;
                ST_RESULT: if (fsm_req_taken) next_state = ST_WAIT;
                ST_WAIT: begin
                    if (own_resp_rcvd && remote_known) begin
                        next_state = ST_EXIT;
                    end else if (timer_expired) begin
                        next_state = ST_EXIT;
                        next_exit  = EXIT_TIMEOUT;
                    end
                end
                ST_EXIT:   next_state = ST_EXIT;
                default:   next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_point_test_en = (state == ST_TEST);
        o_exit          = (state == ST_EXIT) ? exit_code : EXIT_NONE;
        o_ack           = (state == ST_EXIT) && (timer == '0);
        fsm_req_valid   = ((state == ST_START) && !start_req_sent) || (state == ST_RESULT);
        fsm_req_code    = (state == ST_START) ? MSG_START_REQ : verdict_req(local_verdict);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_req_sent     <= 1'b0;
            start_resp_rcvd    <= 1'b0;
            start_answered     <= 1'b0;
            own_resp_rcvd      <= 1'b0;
            remote_known       <= 1'b0;
            remote_verdict     <= EXIT_NONE;
            local_verdict      <= EXIT_NONE;
            exit_code          <= EXIT_NONE;
            lanes_all_pass     <= 1'b0;
            o_group_functional <= '0;
        end else if (!i_en || state == ST_IDLE) begin
            start_req_sent     <= 1'b0;
            start_resp_rcvd    <= 1'b0;
            start_answered     <= 1'b0;
            own_resp_rcvd      <= 1'b0;
            remote_known       <= 1'b0;
            remote_verdict     <= EXIT_NONE;
            local_verdict      <= EXIT_NONE;
            exit_code          <= EXIT_NONE;
            lanes_all_pass     <= 1'b0;
            o_group_functional <= '0;
        end else begin
            if (state == ST_START && fsm_req_taken) start_req_sent <= 1'b1;
            if (o_valid && o_sideband_message == MSG_START_RESP) start_answered <= 1'b1;
            if (rx_active && i_sideband_message == MSG_START_RESP) start_resp_rcvd <= 1'b1;
            if (rx_active && state == ST_WAIT && i_sideband_message == own_resp_code) begin
                own_resp_rcvd <= 1'b1;
            end
            if (rx_active && rx_verdict != EXIT_NONE) begin
                remote_known   <= 1'b1;
                remote_verdict <= rx_verdict;
            end
            if (state == ST_TEST && i_point_test_ack) begin
                o_group_functional <= group_pass;
                lanes_all_pass     <= &i_lanes_result;
            end
            if (state == ST_EVAL) local_verdict <= eval_verdict;
            if (next_state == ST_EXIT && state != ST_EXIT) exit_code <= next_exit;
        end
    end

endmodule

// File: doc/linkspeed_seq.md
# linkspeed_seq

Parametrised LINKSPEED sequencer for MBTRAIN: drives the local start/point-test/result exchange and answers the partner's LINKSPEED requests in one block. Lanes are generalised to N lanes in G repairable groups. A per-phase timeout is added. Local and remote outcomes are resolved to the single most severe exit. It sits between the MBTRAIN FSM, the point-test block and the sideband TX/RX path.

## Interface
- NUM_LANES, 16: mainband data lanes tested.
- NUM_GROUPS, 2: repair groups; must divide NUM_LANES.
- TIMEOUT_CYCLES, 800000: per-phase timeout (8 ms at 100 MHz).
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- i_en  in  1  level; LINKSPEED active while high; low returns to IDLE next cycle.
- i_sideband_message  in  4  received message code.
- i_sideband_valid  in  1  1-cycle strobe qualifying i_sideband_message.
- i_busy  in  1  sideband TX busy; no o_valid issued while high.
- i_point_test_ack  in  1  1-cycle point-test completion.
- i_lanes_result  in  NUM_LANES  per-lane pass (1) / fail, valid with ack.
- i_valid_framing_error  in  1  sticky-until-IDLE framing error.
- i_comming_from_repair  in  1  repair already attempted this training.
- o_valid  out  1  1-cycle sideband send strobe.
- o_sideband_message  out  4  code sent with o_valid; held otherwise.
- o_point_test_en  out  1  high from TEST entry until ack.
- o_group_functional  out  NUM_GROUPS  per-group all-lanes-pass, latched at ack.
- o_exit  out  3  one-hot-free code: 0 none, 1 done, 2 repair, 3 speed degrade, 4 phy retrain, 5 timeout.
- o_ack  out  1  1-cycle pulse when o_exit becomes valid.

## Operation
- States: IDLE, START, TEST, EVAL, RESULT, WAIT, EXIT.
- IDLE: i_en rise -> START.
- START: send START_REQ; wait until START_RESP received AND partner START_REQ answered -> TEST.
- TEST: o_point_test_en=1; on ack latch lanes, compute groups -> EVAL.
- EVAL (1 cycle) local verdict:
  - framing error -> PHYRETRAIN.
  - All lanes pass -> DONE.
  - At least one group functional, NUM_GROUPS>1 and !i_comming_from_repair -> REPAIR.
  - Else SPEED_DEGRADE.
- RESULT: send the verdict REQ -> WAIT.
- WAIT: remote verdict REQ (received in any state after START) is answered with matching RESP. Leave on receipt of own RESP AND remote verdict known.
- Final exit = max severity(local, remote); order PHYRETRAIN > SPEED_DEGRADE > REPAIR > DONE.
- EXIT: o_exit held, o_ack pulse on entry; stays until i_en low.
- Responder: partner REQ queued in a 1-deep pending register. If a second REQ arrives while one is pending, the newest overwrites it.
- Arbiter: pending RESP beats FSM REQ when both are ready in the same cycle. The REQ is issued in the next free cycle.
- Message codes, fixed:
  - START_REQ 1, START_RESP 2
  - DONE_REQ 3, DONE_RESP 4
  - REPAIR_REQ 5, REPAIR_RESP 6
  - DEGRADE_REQ 7, DEGRADE_RESP 8
  - RETRAIN_REQ 9, RETRAIN_RESP 10
  - Other codes ignored.

## Timing
- Reset:
  - Outputs: o_valid=0, o_sideband_message=0, o_point_test_en=0, o_group_functional=0, o_exit=0, o_ack=0.
  - Internal: state IDLE, counter 0, pending empty.
- o_valid asserted one cycle after a message becomes sendable with i_busy=0. Never in two consecutive cycles: at least one idle cycle between sends.
- i_sideband_valid and i_busy act in the cycle sampled. An RX strobe coinciding with an own send is still captured.
- Timeout counter resets on every state change. At TIMEOUT_CYCLES-1 in START/TEST/WAIT -> EXIT with o_exit=5.
- i_en low mid-operation:
  - Next cycle IDLE, all outputs to reset values, pending cleared.
  - A send pulsed that cycle completes; nothing further is sent.
- Ack arriving outside TEST is ignored.

## Structure
- Package linkspeed_pkg: message code constants, exit code constants, state enum, severity function.
- Sub-module linkspeed_resp_arb: pending-response register plus REQ/RESP arbiter with busy/gap rule.
- Group reduction uses a generate loop (AND over NUM_LANES/NUM_GROUPS slices).

## Test plan
- Clean run, both sides pass:
  - Stimulus: start exchange, ack with lanes=16'hFFFF, partner DONE_REQ.
  - Expect: sends 1, 2, 3, 4 in legal order; o_exit=1; o_ack once.
- Repairable:
  - Stimulus: lanes=16'h00FF, !from_repair, partner DONE_REQ.
  - Expect: o_group_functional=2'b01, REPAIR_REQ sent, o_exit=2.
- Same failure with i_comming_from_repair=1:
  - Expect: DEGRADE_REQ sent, o_exit=3.
- Remote more severe:
  - Stimulus: local DONE, partner RETRAIN_REQ arrives during RESULT.
  - Expect: RETRAIN_RESP sent before DONE_REQ; o_exit=4.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=100, no START_RESP.
  - Expect: o_exit=5 at cycle 100 after START entry.
- Busy/abort:
  - Stimulus: i_busy high 20 cycles during RESULT. Then i_en low while in WAIT.
  - Expect: no o_valid while busy. IDLE next cycle after i_en low, all outputs 0.
